// File: rtl/clk_period_monitor.sv
// Rise-to-rise period monitor for an asynchronous clock, measured in clk_i cycles, with lock detection.
// Optional min/max period tracking is enabled by defining CLK_PERIOD_MON_MINMAX_EN.
module clk_period_monitor #(
    parameter int width_p        = 16,
    parameter int sync_stages_p  = 2,
    parameter int stable_count_p = 4,
    parameter int tolerance_p    = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               mon_clk_i,
    input  logic               en_i,
    input  logic               clear_i,
    output logic [width_p-1:0] period_o,
    output logic               period_v_o,
    output logic               change_o,
    output logic               locked_o,
    output logic               overflow_o
`ifdef CLK_PERIOD_MON_MINMAX_EN
    ,
    output logic [width_p-1:0] min_period_o,
    output logic [width_p-1:0] max_period_o
`endif
);

    localparam int stable_w_lp = $clog2(stable_count_p + 1);
    localparam logic [width_p-1:0]     cnt_max_lp    = '1;
    localparam logic [width_p-1:0]     tol_lp        = width_p'(tolerance_p);
    localparam logic [stable_w_lp-1:0] stable_max_lp = stable_w_lp'(stable_count_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t                   state_q, state_next;
    logic [sync_stages_p-1:0] sync_q;
    logic                     mon_level_d;
    logic                     rise_q;
    logic [width_p-1:0]       cnt_q;
    logic [stable_w_lp-1:0]   stable_q;
    logic                     has_prev_q;
    logic                     report;
    logic                     overflow_hit;
    logic                     mon_level;

    function automatic logic [width_p-1:0] abs_diff(input logic [width_p-1:0] a,
                                                    input logic [width_p-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [stable_w_lp-1:0] sat_inc(input logic [stable_w_lp-1:0] s);
        return (s >= stable_max_lp) ? stable_max_lp : (s + stable_w_lp'(1));
    endfunction

    assign mon_level = sync_q[sync_stages_p-1];

    // Synchronizer and registered rising-edge detect
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q      <= '0;
            mon_level_d <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[sync_stages_p-2:0], mon_clk_i};
            mon_level_d <= mon_level;
            rise_q      <= mon_level & ~mon_level_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_next;
    end

    always_comb begin
        state_next   = state_q;
        report       = 1'b0;
        overflow_hit = 1'b0;
        case (state_q)
            IDLE: if (en_i) state_next = ARM;
            ARM: begin
                if (!en_i)       state_next = IDLE;
                else if (rise_q) state_next = MEAS;
            end
            MEAS: begin
                if (!en_i) begin
                    state_next = IDLE;
                end else if (rise_q) begin
                    report = 1'b1;
                end else if (cnt_q == cnt_max_lp) begin
                    overflow_hit = 1'b1;
                    state_next   = ARM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Period measurement, change and lock tracking
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q      <= '0;
            stable_q   <= '0;
            has_prev_q <= 1'b0;
            period_o   <= '0;
            period_v_o <= 1'b0;
            change_o   <= 1'b0;
            locked_o   <= 1'b0;
        end else begin
            period_v_o <= 1'b0;
            change_o   <= 1'b0;
            if (!en_i) begin
                cnt_q      <= '0;
                stable_q   <= '0;
                has_prev_q <= 1'b0;
                locked_o   <= 1'b0;
            end else if (state_q == ARM && rise_q) begin
                cnt_q <= width_p'(1);
            end else if (report) begin
                period_o   <= cnt_q;
                period_v_o <= 1'b1;
                cnt_q      <= width_p'(1);
                has_prev_q <= 1'b1;
                if (!has_prev_q) begin
                    stable_q <= stable_w_lp'(1);
                    locked_o <= (stable_max_lp == stable_w_lp'(1));
                end else if (abs_diff(cnt_q, period_o) > tol_lp) begin
                    change_o <= 1'b1;
                    stable_q <= stable_w_lp'(1);
                    locked_o <= 1'b0;
                end else begin
                    stable_q <= sat_inc(stable_q);
                    locked_o <= (sat_inc(stable_q) == stable_max_lp);
                end
            end else if (overflow_hit) begin
                cnt_q      <= '0;
                stable_q   <= '0;
                has_prev_q <= 1'b0;
                locked_o   <= 1'b0;
            end else if (state_q == MEAS) begin
                cnt_q <= cnt_q + width_p'(1);
            end
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)        overflow_o <= 1'b0;
        else if (overflow_hit) overflow_o <= 1'b1;
        else if (clear_i)      overflow_o <= 1'b0;
    end

`ifdef CLK_PERIOD_MON_MINMAX_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            min_period_o <= '1;
            max_period_o <= '0;
        end else if (clear_i) begin
            min_period_o <= report ? cnt_q : '1;
            max_period_o <= report ? cnt_q : '0;
        end else if (report) begin
            if (cnt_q < min_period_o) min_period_o <= cnt_q;
            if (cnt_q > max_period_o) max_period_o <= cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: three instances (16-bit, 8-bit, tolerance 1) share stimulus.
// Min/max checks compile only when CLK_PERIOD_MON_MINMAX_EN is defined.
module tb_clk_period_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic mon_clk = 1'b0;
    logic en      = 1'b0;
    logic clear   = 1'b0;

    logic [15:0] period16, periodt;
    logic [7:0]  period8;
    logic        v16, ch16, lk16, ov16;
    logic        v8, ch8, lk8, ov8;
    logic        vt, cht, lkt, ovt;
`ifdef CLK_PERIOD_MON_MINMAX_EN
    logic [15:0] min16, max16, mint, maxt;
    logic [7:0]  min8, max8;
`endif

    clk_period_monitor #(.width_p(16), .sync_stages_p(2), .stable_count_p(4), .tolerance_p(0)) dut16 (
        .clk_i(clk), .reset_n_i(reset_n), .mon_clk_i(mon_clk), .en_i(en), .clear_i(clear),
        .period_o(period16), .period_v_o(v16), .change_o(ch16), .locked_o(lk16), .overflow_o(ov16)
`ifdef CLK_PERIOD_MON_MINMAX_EN
        , .min_period_o(min16), .max_period_o(max16)
`endif
    );

    clk_period_monitor #(.width_p(8), .sync_stages_p(2), .stable_count_p(4), .tolerance_p(0)) dut8 (
        .clk_i(clk), .reset_n_i(reset_n), .mon_clk_i(mon_clk), .en_i(en), .clear_i(clear),
        .period_o(period8), .period_v_o(v8), .change_o(ch8), .locked_o(lk8), .overflow_o(ov8)
`ifdef CLK_PERIOD_MON_MINMAX_EN
        , .min_period_o(min8), .max_period_o(max8)
`endif
    );

    clk_period_monitor #(.width_p(16), .sync_stages_p(2), .stable_count_p(4), .tolerance_p(1)) dutt (
        .clk_i(clk), .reset_n_i(reset_n), .mon_clk_i(mon_clk), .en_i(en), .clear_i(clear),
        .period_o(periodt), .period_v_o(vt), .change_o(cht), .locked_o(lkt), .overflow_o(ovt)
`ifdef CLK_PERIOD_MON_MINMAX_EN
        , .min_period_o(mint), .max_period_o(maxt)
`endif
    );

    typedef struct packed {
        logic [15:0] period;
        logic        change;
        logic        locked;
    } rep_t;

    rep_t q16[$];
    rep_t q8[$];
    rep_t qt[$];

    int checks = 0;
    int errors = 0;

    // Report logger, sampled on the inactive edge
    always @(negedge clk) begin
        if (v16) q16.push_back('{period16, ch16, lk16});
        if (v8)  q8.push_back('{{8'h00, period8}, ch8, lk8});
        if (vt)  qt.push_back('{periodt, cht, lkt});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_periods(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            mon_clk = 1'b1;
            cyc(p / 2);
            mon_clk = 1'b0;
            cyc(p - p / 2);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        clear   = 1'b0;
        mon_clk = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        q16.delete();
        q8.delete();
        qt.delete();
    endtask

    task automatic start_meas();
        en = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        mon_clk = 1'b0;
        cyc(3);
        checks++;
        if ({period16, v16, ch16, lk16, ov16} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs16 got %h expected 0", {period16, v16, ch16, lk16, ov16});
        end
        checks++;
        if ({period8, ov8, lk8} !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs8 got %h expected 0", {period8, ov8, lk8});
        end
`ifdef CLK_PERIOD_MON_MINMAX_EN
        checks++;
        if (min16 !== 16'hFFFF || max16 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_minmax got min %h max %h expected ffff/0000", min16, max16);
        end
`endif
        do_reset();
    endtask

    task automatic test_latency();
        int lat;
        do_reset();
        start_meas();
        mon_periods(10, 1);
        mon_clk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (v16 && lat == 0) lat = k;
        end
        mon_clk = 1'b0;
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL latency got %0d edges expected 4 (0 = no report)", lat);
        end
        checks++;
        if (period16 !== 16'd10) begin
            errors++;
            $display("FAIL latency_period got %0d expected 10", period16);
        end
    endtask

    task automatic test_steady();
        do_reset();
        start_meas();
        mon_periods(10, 8);
        cyc(5);
        checks++;
        if (q16.size() !== 7) begin
            errors++;
            $display("FAIL steady_count got %0d expected 7", q16.size());
        end
        for (int i = 0; i < q16.size(); i++) begin
            checks++;
            if (q16[i] !== rep_t'{16'd10, 1'b0, (i >= 3)}) begin
                errors++;
                $display("FAIL steady_report[%0d] got p=%0d ch=%0b lk=%0b expected p=10 ch=0 lk=%0b",
                         i, q16[i].period, q16[i].change, q16[i].locked, (i >= 3));
            end
        end
    endtask

    task automatic test_change();
        logic [5:0] exp_lk;
        logic [5:0] exp_ch;
        int         exp_p[6];
        do_reset();
        start_meas();
        mon_periods(10, 6);
        q16.delete();
        mon_periods(14, 6);
        cyc(5);
        exp_p  = '{10, 14, 14, 14, 14, 14};
        exp_ch = 6'b000010;
        exp_lk = 6'b110001;
        checks++;
        if (q16.size() !== 6) begin
            errors++;
            $display("FAIL change_count got %0d expected 6", q16.size());
        end
        for (int i = 0; i < 6 && i < q16.size(); i++) begin
            checks++;
            if (q16[i] !== rep_t'{16'(exp_p[i]), exp_ch[i], exp_lk[i]}) begin
                errors++;
                $display("FAIL change_report[%0d] got p=%0d ch=%0b lk=%0b expected p=%0d ch=%0b lk=%0b",
                         i, q16[i].period, q16[i].change, q16[i].locked, exp_p[i], exp_ch[i], exp_lk[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        start_meas();
        mon_periods(10, 6);
        checks++;
        if (lk8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_prelock got %b expected 1", lk8);
        end
        q8.delete();
        cyc(200);
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got %b expected 0", ov8);
        end
        cyc(100);
        checks++;
        if ({ov8, lk8} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_set got ov=%b lk=%b expected ov=1 lk=0", ov8, lk8);
        end
        checks++;
        if (ov16 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wide got %b expected 0", ov16);
        end
        checks++;
        if (q8.size() !== 0) begin
            errors++;
            $display("FAIL ovf_noreport got %0d reports expected 0", q8.size());
        end
        mon_periods(10, 4);
        cyc(5);
        checks++;
        if (q8.size() !== 3) begin
            errors++;
            $display("FAIL ovf_resume_count got %0d expected 3", q8.size());
        end else begin
            checks++;
            if (q8[0] !== rep_t'{16'd10, 1'b0, 1'b0} || q8[2].locked !== 1'b0) begin
                errors++;
                $display("FAIL ovf_resume_report got p=%0d ch=%0b lk2=%0b expected p=10 ch=0 lk2=0",
                         q8[0].period, q8[0].change, q8[2].locked);
            end
        end
        checks++;
        if (ov8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b expected 1", ov8);
        end
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b expected 0", ov8);
        end
    endtask

    task automatic test_tolerance();
        int chg_t;
        int chg_16;
        do_reset();
        start_meas();
        for (int i = 0; i < 4; i++) begin
            mon_periods(10, 1);
            mon_periods(11, 1);
        end
        cyc(5);
        chg_t  = 0;
        chg_16 = 0;
        foreach (qt[i])  if (qt[i].change)  chg_t++;
        foreach (q16[i]) if (q16[i].change) chg_16++;
        checks++;
        if (qt.size() !== 7 || chg_t !== 0) begin
            errors++;
            $display("FAIL tol1_changes got %0d reports %0d changes expected 7 reports 0 changes", qt.size(), chg_t);
        end
        checks++;
        if (lkt !== 1'b1) begin
            errors++;
            $display("FAIL tol1_locked got %b expected 1", lkt);
        end
        checks++;
        if (chg_16 !== 6) begin
            errors++;
            $display("FAIL tol0_changes got %0d expected 6", chg_16);
        end
        do_reset();
        start_meas();
        for (int i = 0; i < 4; i++) begin
            mon_periods(10, 1);
            mon_periods(12, 1);
        end
        cyc(5);
        chg_t = 0;
        foreach (qt[i]) if (qt[i].change) chg_t++;
        checks++;
        if (chg_t !== 6 || lkt !== 1'b0) begin
            errors++;
            $display("FAIL tol1_wide got %0d changes lk=%b expected 6 changes lk=0", chg_t, lkt);
        end
    endtask

    task automatic test_abort();
        do_reset();
        start_meas();
        mon_periods(10, 6);
        en = 1'b0;
        cyc(1);
        checks++;
        if ({lk16, v16, period16} !== {1'b0, 1'b0, 16'd10}) begin
            errors++;
            $display("FAIL abort_en got lk=%b v=%b p=%0d expected lk=0 v=0 p=10", lk16, v16, period16);
        end
        cyc(3);
        start_meas();
        q16.delete();
        mon_periods(10, 3);
        cyc(5);
        checks++;
        if (q16.size() !== 2) begin
            errors++;
            $display("FAIL abort_rearm_count got %0d expected 2", q16.size());
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({period16, v16, ch16, lk16, ov16} !== 20'h0) begin
            errors++;
            $display("FAIL abort_async_reset got %h expected 0", {period16, v16, ch16, lk16, ov16});
        end
        do_reset();
    endtask

`ifdef CLK_PERIOD_MON_MINMAX_EN
    task automatic test_minmax();
        do_reset();
        start_meas();
        mon_periods(10, 1);
        mon_periods(14, 1);
        mon_periods(8, 1);
        mon_periods(8, 1);
        cyc(5);
        checks++;
        if (min16 !== 16'd8 || max16 !== 16'd14) begin
            errors++;
            $display("FAIL minmax_track got min %0d max %0d expected 8/14", min16, max16);
        end
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        checks++;
        if (min16 !== 16'hFFFF || max16 !== 16'h0000) begin
            errors++;
            $display("FAIL minmax_clear got min %h max %h expected ffff/0000", min16, max16);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_steady();
        test_change();
        test_overflow();
        test_tolerance();
        test_abort();
`ifdef CLK_PERIOD_MON_MINMAX_EN
        test_minmax();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
